// File: rtl/medidor_pkg.sv
// medidor_pkg
// Shared definitions for the ultrasonic distance meter:
//   - FSM state type and the 4-bit codes exposed on db_estado
//   - BCD result width and the 12'h999 code reported on a failed measurement
//   - bcd_inc_sat: saturating +1 on a 3-digit BCD value (stops at 999)
package medidor_pkg;

  localparam int BCD_W = 12;
  localparam logic [BCD_W-1:0] MEDIDA_ERRO = 12'h999;

  localparam logic [3:0] COD_IDLE        = 4'd0;
  localparam logic [3:0] COD_TRIGGER     = 4'd1;
  localparam logic [3:0] COD_ESPERA_ECHO = 4'd2;
  localparam logic [3:0] COD_MEDINDO     = 4'd3;
  localparam logic [3:0] COD_ARREDONDA   = 4'd4;
  localparam logic [3:0] COD_FINAL       = 4'd5;

  typedef enum logic [3:0] {
    IDLE        = COD_IDLE,
    TRIGGER     = COD_TRIGGER,
    ESPERA_ECHO = COD_ESPERA_ECHO,
    MEDINDO     = COD_MEDINDO,
    ARREDONDA   = COD_ARREDONDA,
    FINAL       = COD_FINAL
  } estado_t;

  // Ripple the carry through the three BCD digits; 999 is sticky.
  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (v != MEDIDA_ERRO) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/medidor_distancia_contador_bcd_3dig.sv
// contador_bcd_3dig
// Three-digit BCD centimetre counter, 000..999, saturating at 999.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-low reset (clears the count)
//   clr    in   synchronous clear (higher priority than en)
//   en     in   count enable, +1 per cycle while high
//   valor  out  12-bit BCD count {centena, dezena, unidade}
module contador_bcd_3dig
  import medidor_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] valor
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valor <= '0;
    end else if (clr) begin
      valor <= '0;
    end else if (en) begin
      valor <= bcd_inc_sat(valor);
    end
  end

endmodule

// File: rtl/medidor_distancia.sv
// medidor_distancia
// Ultrasonic distance meter: fires a trigger pulse, times the echo width,
// converts it to centimetres in BCD with round-to-nearest and reports it.
// Optional feature macro: MEDIDOR_TIMEOUT_EN (abort after TIMEOUT cycles
// waiting for/measuring the echo, reporting erro=1 and medida=12'h999).
// Ports:
//   clock      in   50 MHz system clock
//   reset      in   synchronous active-low reset
//   medir      in   start request, honoured only in IDLE
//   echo       in   asynchronous sensor echo (2-flop synchronised)
//   trigger    out  sensor trigger pulse, CICLOS_TRIGGER cycles wide
//   medida     out  distance in BCD {centena, dezena, unidade}, cm
//   pronto     out  one-cycle pulse, medida valid
//   erro       out  one-cycle pulse with pronto when the measurement failed
//   db_estado  out  current FSM state code
module medidor_distancia
  import medidor_pkg::*;
#(
  parameter int CICLOS_CM      = 2941,
  parameter int CICLOS_TRIGGER = 500,
  parameter int TIMEOUT        = 1_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             medir,
  input  logic             echo,
  output logic             trigger,
  output logic [BCD_W-1:0] medida,
  output logic             pronto,
  output logic             erro,
  output logic [3:0]       db_estado
);

  localparam int CW = (CICLOS_CM > 1)      ? $clog2(CICLOS_CM)      : 1;
  localparam int TW = (CICLOS_TRIGGER > 1) ? $clog2(CICLOS_TRIGGER) : 1;

  estado_t          estado, prox_estado;
  logic [TW-1:0]    cnt_trig;
  logic [CW-1:0]    cnt_ciclo;
  logic             ciclo_fim;
  logic             echo_p0, echo_p1;
  logic             bcd_clr, bcd_en;
  logic [BCD_W-1:0] bcd_valor;
  logic             carga_medida;
  logic [BCD_W-1:0] medida_prox;
  logic             falha;
  logic             tmo_fim;

  // Residual of the last partial centimetre decides rounding.
  function automatic logic arredonda_acima(input logic [CW-1:0] resto);
    return resto >= CW'(CICLOS_CM / 2);
  endfunction

  // Stage p0/p1: echo synchroniser
  always_ff @(posedge clock) begin
    if (!reset) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
    end else begin
      echo_p0 <= echo;
      echo_p1 <= echo_p0;
    end
  end

  assign ciclo_fim = (cnt_ciclo == CW'(CICLOS_CM - 1));

`ifdef MEDIDOR_TIMEOUT_EN
  localparam int MW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [MW-1:0] cnt_tmo;

  assign tmo_fim = (cnt_tmo == MW'(TIMEOUT - 1));

  // Runs only while waiting for or measuring the echo; any other state
  // (in particular TRIGGER) leaves it cleared for the next attempt.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_tmo <= '0;
      falha   <= 1'b0;
    end else begin
      if (estado == ESPERA_ECHO || estado == MEDINDO) begin
        cnt_tmo <= cnt_tmo + MW'(1);
        if (tmo_fim) falha <= 1'b1;
      end else begin
        cnt_tmo <= '0;
      end
      if (estado == TRIGGER) falha <= 1'b0;
    end
  end
`else
  assign tmo_fim = 1'b0;
  assign falha   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado    <= IDLE;
      cnt_trig  <= '0;
      cnt_ciclo <= '0;
      medida    <= '0;
    end else begin
      estado <= prox_estado;
      if (estado == TRIGGER) cnt_trig <= cnt_trig + TW'(1);
      else                   cnt_trig <= '0;
      // Held at zero while waiting so MEDINDO always starts from a clean count.
      if (estado == ESPERA_ECHO) begin
        cnt_ciclo <= '0;
      end else if (estado == MEDINDO && echo_p1) begin
        cnt_ciclo <= ciclo_fim ? '0 : cnt_ciclo + CW'(1);
      end
      if (carga_medida) medida <= medida_prox;
    end
  end

  // medida is loaded on the edge that enters FINAL, so it is already valid
  // in the cycle pronto is high.
  always_comb begin
    prox_estado  = estado;
    bcd_clr      = 1'b0;
    bcd_en       = 1'b0;
    carga_medida = 1'b0;
    medida_prox  = bcd_valor;
    case (estado)
      IDLE: begin
        if (medir) prox_estado = TRIGGER;
      end
      TRIGGER: begin
        if (cnt_trig == TW'(CICLOS_TRIGGER - 1)) prox_estado = ESPERA_ECHO;
      end
      ESPERA_ECHO: begin
        if (echo_p1) begin
          prox_estado = MEDINDO;
          bcd_clr     = 1'b1;
        end
        if (tmo_fim) begin
          prox_estado  = FINAL;
          carga_medida = 1'b1;
          medida_prox  = MEDIDA_ERRO;
        end
      end
      MEDINDO: begin
        if (!echo_p1)      prox_estado = ARREDONDA;
        else if (ciclo_fim) bcd_en     = 1'b1;
        if (tmo_fim) begin
          prox_estado  = FINAL;
          carga_medida = 1'b1;
          medida_prox  = MEDIDA_ERRO;
        end
      end
      ARREDONDA: begin
        bcd_en       = arredonda_acima(cnt_ciclo);
        prox_estado  = FINAL;
        carga_medida = 1'b1;
        medida_prox  = bcd_en ? bcd_inc_sat(bcd_valor) : bcd_valor;
      end
      FINAL: begin
        prox_estado = IDLE;
      end
      default: prox_estado = IDLE;
    endcase
  end

  contador_bcd_3dig u_contador (
    .clock (clock),
    .reset (reset),
    .clr   (bcd_clr),
    .en    (bcd_en),
    .valor (bcd_valor)
  );

  assign trigger   = (estado == TRIGGER);
  assign pronto    = (estado == FINAL);
  assign erro      = (estado == FINAL) && falha;
  assign db_estado = estado;

endmodule

// File: tb/tb_medidor_distancia.sv
module tb_medidor_distancia;

  localparam int CM   = 10;
  localparam int TRIG = 5;
  localparam int TMO  = 20000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo  = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  typedef struct {
    logic [11:0] medida;
    logic        erro;
  } esperado_t;

  esperado_t fila[$];
  int n_chk  = 0;
  int n_fail = 0;

  medidor_distancia #(
    .CICLOS_CM      (CM),
    .CICLOS_TRIGGER (TRIG),
    .TIMEOUT        (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic pulsa_medir();
    medir = 1'b1;
    ciclo();
    medir = 1'b0;
  endtask

  // Waits for trigger to rise, then checks its width in cycles.
  task automatic espera_trigger(input string nome);
    int espera;
    int largura;
    espera  = 0;
    largura = 0;
    while (trigger !== 1'b1 && espera < 200) begin
      ciclo();
      espera++;
    end
    while (trigger === 1'b1 && largura < 1000) begin
      largura++;
      ciclo();
    end
    n_chk++;
    if (largura != TRIG) begin
      n_fail++;
      $display("FAIL %s trigger_width: got %0d cycles, required %0d", nome, largura, TRIG);
    end
  endtask

  task automatic aplica_echo(input int largura);
    repeat (3) ciclo();
    echo = 1'b1;
    repeat (largura) @(posedge clock);
    #1;
    echo = 1'b0;
  endtask

  // Pops the scoreboard when pronto appears and compares inline.
  task automatic espera_pronto(input string nome, input int limite, input int lat_esperada);
    int lat;
    bit achou;
    esperado_t e;
    lat   = 0;
    achou = 1'b0;
    while (!achou && lat < limite) begin
      ciclo();
      lat++;
      if (pronto === 1'b1) achou = 1'b1;
    end
    n_chk++;
    if (!achou) begin
      n_fail++;
      $display("FAIL %s pronto_arrival: no pronto within %0d cycles, required pronto=1", nome, limite);
      if (fila.size() > 0) fila.delete(0);
    end else begin
      e = fila.pop_front();
      n_chk++;
      if (medida !== e.medida) begin
        n_fail++;
        $display("FAIL %s medida: got %h, required %h", nome, medida, e.medida);
      end
      n_chk++;
      if (erro !== e.erro) begin
        n_fail++;
        $display("FAIL %s erro: got %b, required %b", nome, erro, e.erro);
      end
      if (lat_esperada > 0) begin
        n_chk++;
        if (lat != lat_esperada) begin
          n_fail++;
          $display("FAIL %s latency: got %0d cycles, required %0d", nome, lat, lat_esperada);
        end
      end
      ciclo();
      n_chk++;
      if (pronto !== 1'b0) begin
        n_fail++;
        $display("FAIL %s pronto_width: got pronto=%b one cycle later, required 0", nome, pronto);
      end
    end
  endtask

  task automatic faz_medida(input string nome, input int largura, input logic [11:0] esperado,
                            input bit pulsa);
    esperado_t e;
    e.medida = esperado;
    e.erro   = 1'b0;
    fila.push_back(e);
    if (pulsa) pulsa_medir();
    espera_trigger(nome);
    aplica_echo(largura);
    espera_pronto(nome, 100, 4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    medir = 1'b1;
    echo  = 1'b1;
    repeat (3) ciclo();
    n_chk++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL reset trigger: got %b, required 0", trigger); end
    n_chk++;
    if (medida !== 12'h000) begin n_fail++; $display("FAIL reset medida: got %h, required 000", medida); end
    n_chk++;
    if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset pronto: got %b, required 0", pronto); end
    n_chk++;
    if (erro !== 1'b0) begin n_fail++; $display("FAIL reset erro: got %b, required 0", erro); end
    n_chk++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset db_estado: got %0d, required 0", db_estado); end
    medir = 1'b0;
    echo  = 1'b0;
    ciclo();
    reset = 1'b1;
    repeat (3) ciclo();
  endtask

  task automatic test_medicao();
    faz_medida("exact_100",   1000, 12'h100, 1'b1);
    faz_medida("trunc_100",   1003, 12'h100, 1'b1);
    faz_medida("round_up_75",  748, 12'h075, 1'b1);
    faz_medida("trunc_74",     742, 12'h074, 1'b1);
  endtask

  task automatic test_ignora_medir();
    pulsa_medir();
    espera_trigger("ignore_medir");
    repeat (3) ciclo();
    pulsa_medir();
    repeat (3) ciclo();
    n_chk++;
    if (db_estado !== 4'd2) begin
      n_fail++;
      $display("FAIL ignore_medir db_estado: got %0d, required 2", db_estado);
    end
    echo = 1'b1;
    repeat (20) ciclo();
    echo = 1'b0;
    fila.push_back('{medida: 12'h002, erro: 1'b0});
    espera_pronto("ignore_medir", 100, 4);
  endtask

  task automatic test_back_to_back();
    medir = 1'b1;
    faz_medida("b2b_100a", 1000, 12'h100, 1'b0);
    faz_medida("b2b_100b", 1003, 12'h100, 1'b0);
    faz_medida("b2b_074",   742, 12'h074, 1'b0);
    faz_medida("b2b_075",   748, 12'h075, 1'b0);
    medir = 1'b0;
    repeat (10) ciclo();
    n_chk++;
    if (medida !== 12'h075) begin
      n_fail++;
      $display("FAIL hold medida: got %h, required 075", medida);
    end
    n_chk++;
    if (db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL hold db_estado: got %0d, required 0", db_estado);
    end
  endtask

  task automatic test_reset_medindo();
    bit viu_pronto;
    pulsa_medir();
    espera_trigger("reset_mid");
    echo = 1'b1;
    repeat (50) ciclo();
    n_chk++;
    if (db_estado !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_mid pre_state: got %0d, required 3", db_estado);
    end
    reset = 1'b0;
    ciclo();
    n_chk++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_mid db_estado: got %0d, required 0", db_estado); end
    n_chk++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL reset_mid trigger: got %b, required 0", trigger); end
    n_chk++;
    if (medida !== 12'h000) begin n_fail++; $display("FAIL reset_mid medida: got %h, required 000", medida); end
    reset = 1'b1;
    echo  = 1'b0;
    viu_pronto = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ciclo();
      if (pronto === 1'b1) viu_pronto = 1'b1;
    end
    n_chk++;
    if (viu_pronto) begin
      n_fail++;
      $display("FAIL reset_mid no_pronto: got pronto=1 after abort, required 0");
    end
    faz_medida("after_reset", 1000, 12'h100, 1'b1);
  endtask

  task automatic test_timeout();
`ifdef MEDIDOR_TIMEOUT_EN
    fila.push_back('{medida: 12'h999, erro: 1'b1});
    pulsa_medir();
    espera_trigger("timeout");
    espera_pronto("timeout", TMO + 50, TMO);
`else
    pulsa_medir();
    espera_trigger("no_timeout");
    repeat (300) ciclo();
    n_chk++;
    if (db_estado !== 4'd2) begin
      n_fail++;
      $display("FAIL no_timeout db_estado: got %0d, required 2", db_estado);
    end
    n_chk++;
    if (pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout pronto: got %b, required 0", pronto);
    end
    reset = 1'b0;
    ciclo();
    reset = 1'b1;
    ciclo();
`endif
  endtask

  task automatic test_saturacao();
    faz_medida("saturate_999", 10100, 12'h999, 1'b1);
  endtask

  initial begin
    test_reset();
    test_medicao();
    test_ignora_medir();
    test_back_to_back();
    test_reset_medindo();
    test_timeout();
    test_saturacao();
    n_chk++;
    if (fila.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", fila.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/medidor_distancia.md
MEDIDOR_DISTANCIA -- requirements
Module: medidor_distancia

Interface
REQ-001 Parameter CICLOS_CM, 2941, clock cycles per centimetre of echo width (58.82 us at 50 MHz).
REQ-002 Parameter CICLOS_TRIGGER, 500, trigger pulse width in cycles (10 us).
REQ-003 Parameter TIMEOUT, 1_500_000, maximum cycles allowed in ESPERA_ECHO or MEDINDO (30 ms).
REQ-004 clock  in  1  system clock, 50 MHz; sole clock of the block.
REQ-005 reset  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-006 medir  in  1  start request; sampled high in IDLE starts one measurement.
REQ-007 echo  in  1  sensor echo; asynchronous, synchronised internally by a 2-flop chain.
REQ-008 trigger  out  1  sensor trigger pulse.
REQ-009 medida  out  12  distance as 3 BCD digits {centena, dezena, unidade}, in cm.
REQ-010 pronto  out  1  one-cycle pulse: medida is valid and updated.
REQ-011 erro  out  1  one-cycle pulse concurrent with pronto when measurement failed.
REQ-012 db_estado  out  4  current FSM state encoding, for debug.

Function
REQ-013 FSM states: IDLE, TRIGGER, ESPERA_ECHO, MEDINDO, ARREDONDA, FINAL.
REQ-014 IDLE -> TRIGGER when medir=1; medir while not in IDLE is ignored.
REQ-015 TRIGGER drives trigger=1 for exactly CICLOS_TRIGGER cycles, then -> ESPERA_ECHO; trigger=0 in all other states.
REQ-016 ESPERA_ECHO -> MEDINDO on first cycle synchronised echo=1; cycle and BCD counters cleared on entry to MEDINDO.
REQ-017 MEDINDO: cycle counter increments each cycle; at CICLOS_CM-1 it wraps to 0 and BCD counter increments by 1 cm.
REQ-018 MEDINDO -> ARREDONDA on synchronised echo=0.
REQ-019 ARREDONDA: if residual cycle count >= CICLOS_CM/2 (integer), BCD +1; then -> FINAL (one cycle).
REQ-020 BCD counter saturates at 999; no wrap to 000.
REQ-021 FINAL: medida registered from BCD counter, pronto=1 for one cycle, -> IDLE.
REQ-022 Latency echo falling edge (at pin) to pronto: exactly 4 cycles (2 sync + ARREDONDA + FINAL).
REQ-023 medida holds last value until next FINAL; back-to-back medir in the cycle after pronto is accepted.

Reset
REQ-024 reset=0 forces IDLE, trigger=0, medida=12'h000, pronto=0, erro=0, all counters 0, sync flops 0.
REQ-025 reset mid-measurement aborts it with no pronto; trigger drops in the same cycle reset is sampled.

Configuration
REQ-026 With MEDIDOR_TIMEOUT_EN defined: a timeout counter, cleared on TRIGGER exit, runs in ESPERA_ECHO and MEDINDO; reaching TIMEOUT -> FINAL with erro=1, pronto=1, medida=12'h999.
REQ-027 Without MEDIDOR_TIMEOUT_EN: no timeout counter; ESPERA_ECHO/MEDINDO wait indefinitely; erro tied 0.

Structure
REQ-028 Package medidor_pkg holds state enum type, state encodings for db_estado, BCD width constant, and the 12'h999 error code.
REQ-029 One sub-module contador_bcd_3dig: synchronous clear, enable, saturating 000..999 BCD counter.

Verification
REQ-030 Echo 5882 us after trigger -> pronto with medida=12'h100, erro=0.
REQ-031 Echo 5899 us -> medida=12'h100 (residual below half, truncated); echo 4399 us -> medida=12'h075 (rounded up); echo 4353 us -> 12'h074.
REQ-032 medir=1 held continuously with four echoes of 5882/5899/4353/4399 us -> four pronto pulses, medida 100/100/074/075, trigger width 500 cycles each.
REQ-033 MEDIDOR_TIMEOUT_EN defined, no echo after trigger -> pronto and erro at TIMEOUT cycles, medida=12'h999; undefined -> FSM stays in ESPERA_ECHO.
REQ-034 reset=0 asserted during MEDINDO (echo high) -> next cycle IDLE, trigger=0, medida=000, no pronto; next medir measures normally.
REQ-035 Echo 60 ms with timeout off -> medida saturates at 12'h999, erro=0.
